ota_bitstream_decimator: RTL and testbench



---
 rtl/ota_bitstream_decimator.sv | 141 ++++++++++++++
 tb/tb_ota_bitstream_decimator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ota_bitstream_decimator.sv
// Counts synchronised comparator ones over a 2^CNT_W sample window and reports the level.
// Optional 3-tap majority glitch filter: define OTA_DECIM_GLITCH_FILTER_EN.
module ota_bitstream_decimator #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    output logic [CNT_W-1:0] result,
    output logic             sat,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SettleLast = SW'((SETTLE == 0) ? 0 : SETTLE - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StAccum  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             cmp_meta_q, cmp_s_q;
    logic             cmp_cnt;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W:0]   acc_q, acc_d;
    logic [CNT_W-1:0] result_q;
    logic             sat_q, valid_q;
    logic             commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= cmp_in;
            cmp_s_q    <= cmp_meta_q;
        end
    end

`ifdef OTA_DECIM_GLITCH_FILTER_EN
    logic [2:0] taps_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= {taps_q[1:0], cmp_s_q};
        end
    end

    assign cmp_cnt = (taps_q[0] & taps_q[1]) | (taps_q[1] & taps_q[2]) | (taps_q[0] & taps_q[2]);
`else
    assign cmp_cnt = cmp_s_q;
`endif

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        commit       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    settle_cnt_d = '0;
                    win_cnt_d    = '0;
                    acc_d        = '0;
                    state_d      = (SETTLE == 0) ? StAccum : StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_cnt_q == SettleLast) begin
                    state_d = StAccum;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            StAccum: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d     = acc_q + {{CNT_W{1'b0}}, cmp_cnt};
                    win_cnt_d = win_cnt_q + CNT_W'(1);
                    if (win_cnt_q == {CNT_W{1'b1}}) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // The result commits even when aborted here; abort only blocks the re-arm.
                commit = 1'b1;
                if (continuous && !abort) begin
                    state_d   = StAccum;
                    acc_d     = '0;
                    win_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            sat_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            valid_q      <= commit;
            if (commit) begin
                // acc top bit set means every sample was one: clip to all-ones.
                result_q <= acc_q[CNT_W] ? {CNT_W{1'b1}} : acc_q[CNT_W-1:0];
                sat_q    <= acc_q[CNT_W];
            end
        end
    end

    assign result = result_q;
    assign sat    = sat_q;
    assign valid  = valid_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Bench for ota_bitstream_decimator: directed table, corner sequences and a random run
// checked every cycle against an edge-arithmetic reference model (SETTLE=4 and SETTLE=0).
module tb_ota_bitstream_decimator;

    localparam int WIN = 16;
    localparam int HMAX = 16383;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmp_in, start, continuous, abort;
    logic [3:0] result, result0;
    logic       sat, sat0, valid, valid0, busy, busy0;

    ota_bitstream_decimator #(.CNT_W(4), .SETTLE(4)) u_dut (
        .clk(clk), .rst(rst), .cmp_in(cmp_in), .start(start), .continuous(continuous),
        .abort(abort), .result(result), .sat(sat), .valid(valid), .busy(busy)
    );

    ota_bitstream_decimator #(.CNT_W(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .cmp_in(cmp_in), .start(start), .continuous(continuous),
        .abort(abort), .result(result0), .sat(sat0), .valid(valid0), .busy(busy0)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[n] is the comparator level as seen by the edge numbered n (forced 0 under reset).
    logic       hist [0:HMAX];
    int         n_edge = 0;
    logic       mb  [2];
    int         mdue[2];
    logic [3:0] mr  [2];
    logic       ms  [2];
    logic       ev  [2];

    function automatic int hv(input int idx);
        if (idx < 1 || idx > HMAX) return 0;
        return hist[idx] ? 1 : 0;
    endfunction

    // Sample counted by the accumulator update at edge x: input delayed by the synchroniser
    // (and by the majority filter when present).
    function automatic int sample(input int x);
`ifdef OTA_DECIM_GLITCH_FILTER_EN
        int s;
        s = hv(x - 3) + hv(x - 4) + hv(x - 5);
        return (s >= 2) ? 1 : 0;
`else
        return hv(x - 2);
`endif
    endfunction

    // The result committed at edge v covers the 16 accumulator edges just before it.
    function automatic int window(input int v);
        int c;
        c = 0;
        for (int x = v - WIN; x < v; x++) c += sample(x);
        return c;
    endfunction

    always begin
        logic r, s, c, a;
        int   cnt, st;
        @(posedge clk);
        n_edge++;
        r = rst; s = start; c = continuous; a = abort;
        if (n_edge <= HMAX) hist[n_edge] = r ? 1'b0 : cmp_in;
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? 4 : 0;
            ev[i] = 1'b0;
            if (r) begin
                mb[i] = 1'b0; mr[i] = 4'd0; ms[i] = 1'b0;
            end else if (!mb[i]) begin
                if (s) begin
                    mb[i] = 1'b1;
                    mdue[i] = n_edge + st + WIN + 1;
                end
            end else if (n_edge == mdue[i]) begin
                ev[i] = 1'b1;
                cnt = window(n_edge);
                mr[i] = (cnt == WIN) ? 4'hf : 4'(cnt);
                ms[i] = (cnt == WIN);
                if (c && !a) mdue[i] = n_edge + WIN + 1;
                else mb[i] = 1'b0;
            end else if (a) begin
                mb[i] = 1'b0;
            end
        end
        #1;
        chk($sformatf("model_s4 edge %0d {valid,busy,sat,result}", n_edge),
            {25'd0, valid, busy, sat, result}, {25'd0, ev[0], mb[0], ms[0], mr[0]});
        chk($sformatf("model_s0 edge %0d {valid,busy,sat,result}", n_edge),
            {25'd0, valid0, busy0, sat0, result0}, {25'd0, ev[1], mb[1], ms[1], mr[1]});
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        int         mode;
        logic [3:0] res;
        logic       sat;
    } vec_t;

    vec_t vecs [5];

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (k % 2) == 1;
            3: return k == 10;
            default: return (k >= 8 && k <= 10);
        endcase
    endfunction

    task automatic run_single(input int mode, output int lat, output int lat0,
                              output logic [3:0] r, output logic s,
                              output logic busy_first, output logic busy_after);
        lat = -1; lat0 = -1; r = 4'd0; s = 1'b0; busy_first = 1'b0;
        @(negedge clk);
        start = 1'b1; cmp_in = pat(mode, 0);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            start = 1'b0; cmp_in = pat(mode, k);
            if (k == 1) busy_first = busy;
            if (valid0 && lat0 < 0) lat0 = k - 1;
            if (valid) begin
                lat = k - 1; r = result; s = sat;
            end
        end
        @(negedge clk);
        busy_after = busy;
        cmp_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int lat, lat0, nv, vcnt;
        int vedge [3];
        logic [3:0] r, prior;
        logic s, bf, ba;

        vecs[0] = '{1, 4'd15, 1'b1};
        vecs[1] = '{2, 4'd8,  1'b0};
        vecs[2] = '{0, 4'd0,  1'b0};
`ifdef OTA_DECIM_GLITCH_FILTER_EN
        vecs[3] = '{3, 4'd0,  1'b0};
`else
        vecs[3] = '{3, 4'd1,  1'b0};
`endif
        vecs[4] = '{4, 4'd3,  1'b0};

        // Reset with random inputs and start held high.
        rst = 1'b1; start = 1'b1; cmp_in = 1'b0; continuous = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_in = 1'($urandom); continuous = 1'($urandom); abort = 1'($urandom);
            chk("reset_outputs", {25'd0, valid, busy, sat, result}, 32'd0);
        end
        rst = 1'b0; continuous = 1'b0; abort = 1'b0; cmp_in = 1'b0;
        @(negedge clk);
        chk("busy_after_rst_release", {31'd0, busy}, 32'd1);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("abort_in_settle_busy", {31'd0, busy}, 32'd0);
        abort = 1'b0;
        repeat (8) @(negedge clk);

        // Single-shot conversions from the table.
        for (int i = 0; i < 5; i++) begin
            run_single(vecs[i].mode, lat, lat0, r, s, bf, ba);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd21);
            chk($sformatf("vec%0d latency_settle0", i), 32'(lat0), 32'd17);
            chk($sformatf("vec%0d result", i), {28'd0, r}, {28'd0, vecs[i].res});
            chk($sformatf("vec%0d sat", i), {31'd0, s}, {31'd0, vecs[i].sat});
            chk($sformatf("vec%0d busy_next", i), {31'd0, bf}, 32'd1);
            chk($sformatf("vec%0d busy_after_valid", i), {31'd0, ba}, 32'd0);
        end

        // Continuous mode, dropped after the second strobe.
        nv = 0;
        @(negedge clk);
        continuous = 1'b1; cmp_in = 1'b1; start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) begin
                if (nv < 3) vedge[nv] = k - 1;
                nv++;
                chk("cont_result", {28'd0, result}, 32'd15);
                if (nv == 2) continuous = 1'b0;
            end
        end
        chk("cont_valid_count", 32'(nv), 32'd3);
        if (nv >= 3) begin
            chk("cont_first", 32'(vedge[0]), 32'd21);
            chk("cont_spacing1", 32'(vedge[1] - vedge[0]), 32'd17);
            chk("cont_spacing2", 32'(vedge[2] - vedge[1]), 32'd17);
        end
        chk("cont_idle_at_end", {31'd0, busy}, 32'd0);

        // Abort five cycles into ACCUM with zeros on the input: prior result must survive.
        prior = result;
        cmp_in = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (k == 9);
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_next", {31'd0, busy}, 32'd0);
        vcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 32'd0);
        chk("abort_result_kept", {28'd0, result}, {28'd0, prior});

        // Start pulses while busy must not launch extra conversions.
        @(negedge clk);
        start = 1'b1;
        vcnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k % 3 == 0) && (k < 15);
            if (valid) vcnt++;
        end
        chk("start_while_busy_valids", 32'(vcnt), 32'd1);

        // Start and abort together in IDLE: start wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", {31'd0, busy}, 32'd1);
        repeat (30) @(negedge clk);

        // Random run; the per-cycle model does the checking.
        for (int k = 0; k < 3000; k++) begin
            int dens;
            if (k % 40 == 0) dens = $urandom_range(0, 100);
            @(negedge clk);
            cmp_in     = ($urandom_range(0, 99) < dens);
            start      = ($urandom_range(0, 7) == 0);
            if (k % 50 == 0) continuous = 1'($urandom);
            abort      = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
